// File: rtl/apb_cmd_master.sv
// apb_cmd_master: queues read/write commands in a 4-entry FIFO and issues each
// one as an APB transfer. Each transfer returns one response, which is held
// until it is accepted.
//
// Ports:
//   PCLK, PRESET                - clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready         - command handshake (cmd_ready = FIFO not full)
//   cmd_write/addr/wdata/strb   - command payload
//   rsp_valid/rsp_ready         - response handshake
//   rsp_rdata, rsp_timeout      - captured PRDATA (0 for writes/timeouts), abort flag
//   PSELx..PSTRB                - APB requester outputs
//   PRDATA, PREADY              - APB completer inputs
module apb_cmd_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NBYTES     = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [NBYTES-1:0]     cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [NBYTES-1:0]     PSTRB,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH + NBYTES;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;
  state_e state_q, state_d;

  // Command FIFO
  logic [EW-1:0]         fifo_q [4];
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic [2:0]            count_q;
  logic                  push, pop;
  logic                  h_write;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [DATA_WIDTH-1:0] h_wdata;
  logic [NBYTES-1:0]     h_strb;

  // Transfer and response registers
  logic                  xwrite_q;
  logic [ADDR_WIDTH-1:0] xaddr_q;
  logic [DATA_WIDTH-1:0] xwdata_q;
  logic [NBYTES-1:0]     xstrb_q;
  logic [7:0]            wait_q, wait_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rto_q, rto_d;
  logic                  expire;

  // Gated with PRESET so cmd_ready is low throughout reset and rises as soon
  // as reset is released.
  assign cmd_ready = ~PRESET & (count_q != 3'd4);
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state_q == S_IDLE) & (count_q != 3'd0);
  assign {h_write, h_addr, h_wdata, h_strb} = fifo_q[rd_ptr_q];

  // The counter would reach TIMEOUT on this cycle's increment.
  assign expire = (state_q == S_ACCESS) & ~PREADY & (wait_q == TO_LAST);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pop) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (PREADY || expire) state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PSELx     = 1'b0;
    PENABLE   = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_SETUP:  PSELx = 1'b1;
      S_ACCESS: begin
        PSELx   = 1'b1;
        PENABLE = 1'b1;
      end
      S_RESP:   rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  assign PWRITE      = xwrite_q;
  assign PADDR       = xaddr_q;
  assign PWDATA      = xwdata_q;
  assign PSTRB       = xstrb_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_timeout = rto_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge PCLK) begin
    if (push) fifo_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata, cmd_strb};
  end

  always_comb begin
    wait_d  = wait_q;
    rdata_d = rdata_q;
    rto_d   = rto_q;
    if (state_q == S_SETUP) begin
      wait_d = '0;
    end else if (state_q == S_ACCESS) begin
      if (PREADY) begin
        rdata_d = xwrite_q ? '0 : PRDATA;
        rto_d   = 1'b0;
      end else begin
        wait_d = wait_q + 8'd1;
        if (expire) begin
          rdata_d = '0;
          rto_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      xwrite_q <= 1'b0;
      xaddr_q  <= '0;
      xwdata_q <= '0;
      xstrb_q  <= '0;
      wait_q   <= '0;
      rdata_q  <= '0;
      rto_q    <= 1'b0;
    end else begin
      if (pop) begin
        xwrite_q <= h_write;
        xaddr_q  <= h_addr;
        xwdata_q <= h_wdata;
        xstrb_q  <= h_write ? h_strb : '0;
      end
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      rto_q   <= rto_d;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
module tb_apb_cmd_master;
  localparam int TO = 16;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSELx, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;

  always #5 PCLK = ~PCLK;

  apb_cmd_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NBYTES(4), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  // A command plus how the completer behaves for it (wt = PREADY-low cycles).
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] prdata;
    int unsigned wt;
  } cmd_t;

  typedef struct {
    logic [31:0] d;
    logic        t;
  } rsp_t;

  typedef struct {
    cmd_t        c;
    logic [31:0] er;
    logic        et;
    int unsigned elen;
  } vec_t;

  cmd_t src_q[$];
  cmd_t fifo_m[$];
  rsp_t rexp[$];
  cmd_t cur;
  bit          inflight, acc_done, rsp_seen;
  int unsigned acc_n, last_acc_n;
  int          cyc, last_setup_cyc, last_push_cyc, first_rsp_cyc;
  int          n_rsp, n_acc, psel_cnt;
  int          setup_cyc_q[$];
  logic [31:0] last_rd;
  logic        last_to;
  bit          offer_rand;
  int          rr_mode;
  int          n_chk, n_err;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic err(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: unexpected DUT behaviour at cycle %0d", nm, cyc);
  endtask

  function automatic cmd_t mk(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] s, input logic [31:0] pr, input int unsigned wt);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = wd; c.strb = s; c.prdata = pr; c.wt = wt;
    return c;
  endfunction

  // Reference: ACCESS ends on the PREADY cycle or after TO waiting cycles.
  function automatic int unsigned exp_len(input cmd_t c);
    return (c.wt + 1 > TO) ? TO : c.wt + 1;
  endfunction

  function automatic rsp_t exp_rsp(input cmd_t c);
    rsp_t r;
    r.t = (c.wt >= TO);
    r.d = (r.t || c.wr) ? 32'h0 : c.prdata;
    return r;
  endfunction

  task automatic model_reset();
    src_q.delete(); fifo_m.delete(); rexp.delete(); setup_cyc_q.delete();
    inflight = 0; acc_done = 0; rsp_seen = 0; acc_n = 0;
    last_setup_cyc = -100;
  endtask

  // Check DUT outputs (stable since the last rising edge) against the model.
  task automatic observe();
    if (PSELx) psel_cnt++;
    if (PSELx && !PENABLE) begin
      if (inflight || fifo_m.size() == 0) err("setup_unexpected");
      else begin
        cur = fifo_m.pop_front();
        chk("setup_paddr", PADDR, cur.addr);
        chk("setup_pwrite", PWRITE, cur.wr);
        chk("setup_pwdata", PWDATA, cur.wdata);
        chk("setup_pstrb", PSTRB, cur.wr ? cur.strb : 4'h0);
        if (last_setup_cyc >= 0) chk("setup_spacing_ge4", (cyc - last_setup_cyc) >= 4, 1'b1);
        last_setup_cyc = cyc;
        setup_cyc_q.push_back(cyc);
        inflight = 1; acc_done = 0; acc_n = 0;
        rexp.push_back(exp_rsp(cur));
      end
    end else if (PSELx && PENABLE) begin
      if (!inflight || acc_done || acc_n >= TO) err("access_unexpected");
      chk("access_hold", {PWRITE, PADDR, PWDATA, PSTRB},
          {cur.wr, cur.addr, cur.wdata, cur.wr ? cur.strb : 4'h0});
      acc_n++;
    end else if (inflight && !acc_done) begin
      if (acc_n == 0) err("no_access_after_setup");
      else begin
        chk("access_len", acc_n, exp_len(cur));
        last_acc_n = acc_n;
        acc_done = 1;
      end
    end
    if (!PSELx && PENABLE) err("penable_without_psel");
    if (rsp_valid) begin
      if (!(inflight && acc_done) || rexp.size() == 0) err("rsp_unexpected");
      else begin
        chk("rsp_rdata", rsp_rdata, rexp[0].d);
        chk("rsp_timeout", rsp_timeout, rexp[0].t);
        if (!rsp_seen) begin
          first_rsp_cyc = cyc;
          rsp_seen = 1;
        end
      end
    end else if (inflight && acc_done) err("rsp_missing");
  endtask

  task automatic drive();
    if (src_q.size() > 0 && (!offer_rand || $urandom_range(0, 3) != 0)) begin
      cmd_valid = 1'b1;
      cmd_write = src_q[0].wr; cmd_addr = src_q[0].addr;
      cmd_wdata = src_q[0].wdata; cmd_strb = src_q[0].strb;
    end else begin
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_strb = 4'($urandom);
    end
    rsp_ready = (rr_mode == 0) ? 1'b0 : (rr_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    if (PSELx && PENABLE) begin
      PREADY = (acc_n == cur.wt + 1);
      PRDATA = cur.prdata;
    end else begin
      // Noise outside ACCESS must be ignored by the DUT.
      PREADY = 1'($urandom_range(0, 1));
      PRDATA = $urandom;
    end
  endtask

  task automatic handshakes();
    cmd_t c;
    chk("cmd_ready", cmd_ready, fifo_m.size() != 4);
    if (cmd_valid && cmd_ready) begin
      c = src_q.pop_front();
      fifo_m.push_back(c);
      last_push_cyc = cyc;
      n_acc++;
    end
    if (rsp_valid && rsp_ready && rexp.size() > 0) begin
      void'(rexp.pop_front());
      last_rd = rsp_rdata; last_to = rsp_timeout;
      inflight = 0; acc_done = 0; rsp_seen = 0;
      n_rsp++;
    end
  endtask

  task automatic cycle();
    observe();
    drive();
    #1;
    handshakes();
    @(negedge PCLK);
    cyc++;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n = 0;
    while (n_rsp < target && n < budget) begin
      cycle();
      n++;
    end
    if (n_rsp < target) err("wait_rsp_budget_expired");
  endtask

  vec_t vt[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n0, na;
    n_chk = 0; n_err = 0; cyc = 0; n_rsp = 0; n_acc = 0; psel_cnt = 0;
    last_acc_n = 0; last_push_cyc = 0; first_rsp_cyc = 0;
    model_reset();
    PRESET = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_strb = 0;
    rsp_ready = 0; PRDATA = 0; PREADY = 0;

    // Reset state
    repeat (3) @(negedge PCLK);
    chk("rst_psel", PSELx, 1'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_apb_bus", {PWRITE, PADDR, PWDATA, PSTRB}, '0);
    chk("rst_rsp", {rsp_valid, rsp_rdata, rsp_timeout}, '0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    PRESET = 1'b0;
    #1;
    chk("rst_release_cmd_ready", cmd_ready, 1'b1);

    // Table-driven single transfers on an idle DUT
    vt[0].c = mk(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0BAD0BAD, 0);
    vt[0].er = 32'h0;        vt[0].et = 1'b0; vt[0].elen = 1;
    vt[1].c = mk(1'b0, 32'h10, 32'h55555555, 4'hF, 32'h12345678, 3);
    vt[1].er = 32'h12345678; vt[1].et = 1'b0; vt[1].elen = 4;
    vt[2].c = mk(1'b0, 32'h20, 32'h0, 4'h3, 32'hCAFEF00D, 16);
    vt[2].er = 32'h0;        vt[2].et = 1'b1; vt[2].elen = 16;
    vt[3].c = mk(1'b0, 32'h24, 32'h0, 4'h0, 32'hA5A5A5A5, 15);
    vt[3].er = 32'hA5A5A5A5; vt[3].et = 1'b0; vt[3].elen = 16;
    vt[4].c = mk(1'b1, 32'h30, 32'h11223344, 4'h5, 32'h77777777, 40);
    vt[4].er = 32'h0;        vt[4].et = 1'b1; vt[4].elen = 16;
    vt[5].c = mk(1'b0, 32'h0, 32'h0, 4'hF, 32'hFFFFFFFF, 0);
    vt[5].er = 32'hFFFFFFFF; vt[5].et = 1'b0; vt[5].elen = 1;
    vt[6].c = mk(1'b1, 32'hFFFFFFFC, 32'h0, 4'h0, 32'h89ABCDEF, 1);
    vt[6].er = 32'h0;        vt[6].et = 1'b0; vt[6].elen = 2;

    rr_mode = 1; offer_rand = 0;
    for (int i = 0; i < 7; i++) begin
      src_q.push_back(vt[i].c);
      wait_rsp(n_rsp + 1, 80);
      chk("vec_rdata", last_rd, vt[i].er);
      chk("vec_timeout", last_to, vt[i].et);
      chk("vec_access_len", last_acc_n, vt[i].elen);
      // SETUP two cycles after the push; response after SETUP + ACCESS.
      chk("vec_setup_latency", last_setup_cyc - last_push_cyc, 2);
      chk("vec_rsp_latency", first_rsp_cyc - last_push_cyc, 3 + int'(vt[i].elen));
    end

    // Back-to-back commands: one transfer per 4 cycles
    setup_cyc_q.delete();
    for (int i = 0; i < 3; i++) src_q.push_back(mk(1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'hF, 32'h1000 + 32'(i), 0));
    wait_rsp(n_rsp + 3, 60);
    chk("b2b_setups", setup_cyc_q.size(), 3);
    if (setup_cyc_q.size() == 3) begin
      chk("b2b_gap1", setup_cyc_q[1] - setup_cyc_q[0], 4);
      chk("b2b_gap2", setup_cyc_q[2] - setup_cyc_q[1], 4);
    end

    // FIFO full with responses stalled: 1 in flight + 4 queued
    rr_mode = 0;
    na = n_acc;
    for (int i = 0; i < 6; i++) src_q.push_back(mk(1'(i), 32'h200 + 32'(i * 4), 32'hF00 + 32'(i), 4'(i + 1), 32'hBEE0 + 32'(i), 1));
    repeat (20) cycle();
    chk("full_accepted", n_acc - na, 5);
    chk("full_cmd_ready", cmd_ready, 1'b0);
    rr_mode = 1;
    wait_rsp(n_rsp + 6, 120);

    // Randomized traffic against the reference model
    rr_mode = 2; offer_rand = 1;
    base = n_rsp;
    for (int i = 0; i < 80; i++)
      src_q.push_back(mk(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), $urandom,
                         ($urandom_range(0, 3) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4)));
    wait_rsp(base + 80, 5000);

    // Reset in the middle of ACCESS with two commands queued
    rr_mode = 1; offer_rand = 0;
    for (int i = 0; i < 3; i++) src_q.push_back(mk(1'b0, 32'h300 + 32'(i * 4), 32'h0, 4'hF, 32'h3000 + 32'(i), 10));
    n0 = 0;
    while (!(PSELx && PENABLE) && n0 < 20) begin
      cycle();
      n0++;
    end
    if (!(PSELx && PENABLE)) err("mid_access_not_reached");
    chk("mid_access_queued", fifo_m.size(), 2);
    #2 PRESET = 1'b1;
    cmd_valid = 1'b0;
    #1;
    chk("async_rst_psel", PSELx, 1'b0);
    chk("async_rst_penable", PENABLE, 1'b0);
    chk("async_rst_rsp_valid", rsp_valid, 1'b0);
    chk("async_rst_cmd_ready", cmd_ready, 1'b0);
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    model_reset();
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);
    n0 = psel_cnt; na = n_rsp;
    repeat (25) cycle();
    chk("post_rst_no_transfer", psel_cnt - n0, 0);
    chk("post_rst_no_response", n_rsp - na, 0);
    src_q.push_back(mk(1'b0, 32'h44, 32'h0, 4'hF, 32'h600DF00D, 2));
    wait_rsp(n_rsp + 1, 40);
    chk("post_rst_recover_rdata", last_rd, 32'h600DF00D);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
